// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

    localparam int                CMD_W        = 16;
    localparam logic [CMD_W-1:0]  TIMEOUT_DATA = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } spi_arb_state_t;

    // Width of a counter that must reach cyc-1; never narrower than one bit.
    function automatic int cnt_width(input int cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// winner and wraps, so the previous owner has the lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_win,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    int w_pos;

    // Scan requesters in rotated order and keep the first active one.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_win   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(i_last) + k) % NUM_REQ;
            if (!o_valid && i_req[w_pos]) begin
                o_valid       = 1'b1;
                o_win[w_pos]  = 1'b1;
                o_idx         = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between several command
// sources, with a watchdog that forces every transaction to terminate.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [CMD_W-1:0]         rd_data,
    output logic                     err,
    output logic                     busy,
    output logic                     spi_wrt,
    output logic [CMD_W-1:0]         spi_cmd,
    input  logic                     spi_done,
    input  logic [CMD_W-1:0]         spi_rd_data
);

    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam int               CNT_W   = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    spi_arb_state_t     r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_req_done;
    logic [CMD_W-1:0]   r_rd_data;
    logic               r_err;
    logic               r_spi_wrt;
    logic [CMD_W-1:0]   r_spi_cmd;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_win;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    // Arbitration FSM, watchdog counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_req_done <= '0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_spi_wrt  <= 1'b0;
            r_spi_cmd  <= '0;
            r_cnt      <= '0;
        end else begin
            // NOTE: state uses <= only, so every branch sees the values from before this edge.
            r_spi_wrt  <= 1'b0;
            r_req_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt     <= w_win;
                        r_owner   <= w_idx;
                        r_spi_cmd <= req_cmd[CMD_W*w_idx +: CMD_W];
                        r_cnt     <= '0;
                        r_spi_wrt <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    // A completion on the final watchdog cycle still counts as success.
                    if (spi_done) begin
                        r_rd_data  <= spi_rd_data;
                        r_err      <= 1'b0;
                        r_req_done <= r_gnt;
                        r_state    <= ST_DONE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_rd_data  <= TIMEOUT_DATA;
                        r_err      <= 1'b1;
                        r_req_done <= r_gnt;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_owner;
                    r_gnt   <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign req_done = r_req_done;
    assign rd_data  = r_rd_data;
    assign err      = r_err;
    assign busy     = (r_state != ST_IDLE);
    assign spi_wrt  = r_spi_wrt;
    assign spi_cmd  = r_spi_cmd;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: expected transactions are queued when a
// request is raised and checked when spi_wrt / req_done appear.
module tb_spi_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TMO     = 64;

    typedef struct {
        int          idx;
        logic [15:0] cmd;
        logic [15:0] data;
        logic        err;
        bit          lat_tmo;  // latency measured from BUSY entry instead of spi_done
        bit          gap;      // spi_wrt must follow previous spi_done by 3 cycles
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req;
    logic [31:0] req_cmd;
    logic [1:0]  gnt;
    logic [1:0]  req_done;
    logic [15:0] rd_data;
    logic        err;
    logic        busy;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data = 16'h0000;

    logic [15:0] cmd0 = 16'h0000;
    logic [15:0] cmd1 = 16'h0000;
    int          want   [2] = '{0, 0};
    int          served [2] = '{0, 0};

    logic        resp_fire  = 1'b0;
    logic        spur_pulse = 1'b0;
    bit          resp_en    = 1'b1;
    int          resp_lat   = 5;
    logic [15:0] resp_xor   = 16'h5A5A;
    int          resp_cnt   = 0;
    bit          resp_pend  = 1'b0;
    int          resp_done_cyc = -100;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_wrt = 0;
    int          n_done = 0;
    int          n_pushed = 0;
    exp_t        exp_q[$];

    int          wrt_cyc = 0;
    logic [1:0]  wrt_gnt = '0;
    logic        gnt_moved = 1'b0;
    exp_t        mon_e;

    assign req      = {want[1] != served[1], want[0] != served[0]};
    assign req_cmd  = {cmd1, cmd0};
    assign spi_done = resp_fire | spur_pulse;

    spi_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_cmd     (req_cmd),
        .gnt         (gnt),
        .req_done    (req_done),
        .rd_data     (rd_data),
        .err         (err),
        .busy        (busy),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SPI master stand-in: answers each spi_wrt after resp_lat cycles.
    initial forever begin
        @(negedge clk);
        resp_fire = 1'b0;
        if (rst) begin
            resp_pend = 1'b0;
        end else if (spi_wrt) begin
            resp_pend = resp_en;
            resp_cnt  = resp_lat - 1;
        end else if (resp_pend) begin
            if (resp_cnt == 0) begin
                resp_fire     = 1'b1;
                spi_rd_data   = spi_cmd ^ resp_xor;
                resp_done_cyc = cyc;
                resp_pend     = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
    end

    // Monitor: compares issued commands and completions against the queue.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (spi_wrt) begin
                n_wrt++;
                if (exp_q.size() == 0) begin
                    check("wrt_expected", 0, 1);
                end else begin
                    mon_e = exp_q[0];
                    check("spi_cmd", spi_cmd, mon_e.cmd);
                    check("gnt", gnt, 1 << mon_e.idx);
                    if (mon_e.gap) check("wrt_gap", cyc, resp_done_cyc + 3);
                end
                wrt_cyc   = cyc;
                wrt_gnt   = gnt;
                gnt_moved = 1'b0;
            end else if (busy && gnt != wrt_gnt) begin
                gnt_moved = 1'b1;
            end
            if (req_done != 2'b00) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_expected", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("req_done", req_done, 1 << mon_e.idx);
                    check("rd_data", rd_data, mon_e.data);
                    check("err", err, mon_e.err);
                    if (mon_e.lat_tmo) check("tmo_latency", cyc, wrt_cyc + 1 + TMO);
                    else               check("done_latency", cyc, resp_done_cyc + 1);
                    check("gnt_stable", gnt_moved, 0);
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_done[i]) served[i]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int idx, input logic [15:0] cmd, input logic [15:0] data,
                            input logic e_err, input bit lat_tmo, input bit gap);
        exp_t e;
        e.idx = idx; e.cmd = cmd; e.data = data; e.err = e_err; e.lat_tmo = lat_tmo; e.gap = gap;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, (exp_q.size() == 0 && !busy) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},      gnt, 0);
        check({tag, "_req_done"}, req_done, 0);
        check({tag, "_rd_data"},  rd_data, 0);
        check({tag, "_err"},      err, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_spi_wrt"},  spi_wrt, 0);
        check({tag, "_spi_cmd"},  spi_cmd, 0);
    endtask

    initial begin
        int base_wrt;
        int base_done;
        int k;

        tick(3);
        check_reset_outputs("por");
        #1 rst = 1'b0;

        // Single request with a 40-cycle SPI response.
        tick(1);
        #1 resp_xor = 16'hA4C8; resp_lat = 40; cmd0 = 16'hA4FF;
        base_wrt = n_wrt;
        push_exp(0, 16'hA4FF, 16'h0037, 1'b0, 1'b0, 1'b0);
        want[0]++;
        drain("single_drain", 200);
        check("single_wrt_count", n_wrt - base_wrt, 1);

        // Reset so both simultaneous requesters start from a fresh priority.
        tick(1);
        #1 rst = 1'b1;
        tick(2);
        #1 rst = 1'b0;
        resp_xor = 16'h5A5A; resp_lat = 7; cmd0 = 16'h1111; cmd1 = 16'h2222;
        push_exp(0, 16'h1111, 16'h1111 ^ 16'h5A5A, 1'b0, 1'b0, 1'b0);
        push_exp(1, 16'h2222, 16'h2222 ^ 16'h5A5A, 1'b0, 1'b0, 1'b1);
        want[0]++; want[1]++;
        drain("simul_drain", 200);

        // Both requesters held high for six transactions: strict alternation.
        tick(1);
        #1 resp_lat = 5; cmd0 = 16'h1234; cmd1 = 16'hBEEF;
        for (int t = 0; t < 6; t++) begin
            push_exp(t % 2, (t % 2 == 1) ? 16'hBEEF : 16'h1234,
                     ((t % 2 == 1) ? 16'hBEEF : 16'h1234) ^ 16'h5A5A, 1'b0, 1'b0, t > 0);
        end
        want[0] += 3; want[1] += 3;
        drain("cont_drain", 400);

        // Watchdog: the SPI master never answers.
        tick(1);
        #1 resp_en = 1'b0; cmd0 = 16'hCAFE;
        push_exp(0, 16'hCAFE, 16'h0000, 1'b1, 1'b1, 1'b0);
        want[0]++;
        drain("tmo_drain", TMO + 50);

        // Normal service resumes after a timeout.
        tick(1);
        #1 resp_en = 1'b1; cmd1 = 16'h0F0F;
        push_exp(1, 16'h0F0F, 16'h0F0F ^ 16'h5A5A, 1'b0, 1'b0, 1'b0);
        want[1]++;
        drain("post_tmo_drain", 200);

        // Spurious spi_done while idle must not start anything.
        tick(2);
        base_wrt = n_wrt;
        #1 spur_pulse = 1'b1;
        tick(1);
        #1 spur_pulse = 1'b0;
        check("spur_busy", busy, 0);
        tick(1);
        check("spur_busy2", busy, 0);
        check("spur_gnt", gnt, 0);
        check("spur_wrt", n_wrt - base_wrt, 0);

        // spi_done on the final watchdog cycle wins over the timeout.
        #1 cmd0 = 16'h7E57; resp_lat = TMO;
        push_exp(0, 16'h7E57, 16'h7E57 ^ 16'h5A5A, 1'b0, 1'b1, 1'b0);
        want[0]++;
        drain("tie_drain", TMO + 50);

        // Reset while requester 1 is in BUSY; requester 0 must win afterwards.
        tick(1);
        #1 cmd1 = 16'h3C3C; resp_lat = 30;
        base_wrt = n_wrt;
        push_exp(1, 16'h3C3C, 16'h3C3C ^ 16'h5A5A, 1'b0, 1'b0, 1'b0);
        want[1]++;
        k = 0;
        while (n_wrt == base_wrt && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_wrt_seen", n_wrt - base_wrt, 1);
        tick(3);
        base_done = n_done;
        #1 rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        check("midrst_no_done", n_done - base_done, 0);
        #1 rst = 1'b0;
        push_exp(0, 16'h7E57, 16'h7E57 ^ 16'h5A5A, 1'b0, 1'b0, 1'b0);
        push_exp(1, 16'h3C3C, 16'h3C3C ^ 16'h5A5A, 1'b0, 1'b0, 1'b1);
        want[0]++;
        drain("post_rst_drain", 300);

        // One aborted transaction was issued but never completed.
        check("total_done", n_done, n_pushed - 1);
        check("total_wrt", n_wrt, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
